// File: rtl/cpu_pkg.sv
// Shared definitions for the pipeline: bus widths, bus layouts, exception
// bit positions, one-hot operation bit indices and the divider state enum.
// The packed structs define the field order, and therefore the offsets, of
// id_to_exe_bus and exe_to_mem_bus.
package cpu_pkg;
    localparam int EX_TYPE_W = 6;
    localparam int ALE_BIT   = 5;
    localparam int ID_BUS_W  = 279;
    localparam int EXE_BUS_W = 189;
    localparam int FWD_BUS_W = 39;

    // div_op = {div, mod, divu, modu}
    localparam int DIV_DIV  = 3;
    localparam int DIV_MOD  = 2;
    localparam int DIV_DIVU = 1;
    localparam int DIV_MODU = 0;

    // mul_op = {mul, mulh, mulhu}
    localparam int MUL_MUL   = 2;
    localparam int MUL_MULH  = 1;
    localparam int MUL_MULHU = 0;

    // mem_op = {ld_b, ld_h, ld_w, ld_bu, ld_hu, st_b, st_h, st_w}
    localparam int MEM_LD_B  = 7;
    localparam int MEM_LD_H  = 6;
    localparam int MEM_LD_W  = 5;
    localparam int MEM_LD_BU = 4;
    localparam int MEM_LD_HU = 3;
    localparam int MEM_ST_B  = 2;
    localparam int MEM_ST_H  = 1;
    localparam int MEM_ST_W  = 0;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

    typedef struct packed {
        logic                 csr_we;
        logic [13:0]          csr_num;
        logic [31:0]          csr_wmask;
        logic [31:0]          csr_wvalue;
        logic                 ertn;
        logic [EX_TYPE_W-1:0] ex_type;
        logic [11:0]          alu_op;
        logic [31:0]          src1;
        logic [31:0]          src2;
        logic [31:0]          st_data;
        logic [3:0]           div_op;
        logic [2:0]           mul_op;
        logic [7:0]           mem_op;
        logic                 gr_we;
        logic [4:0]           dest;
        logic [31:0]          pc;
        logic [31:0]          inst;
    } id_bus_t;

    typedef struct packed {
        logic                 csr_we;
        logic [13:0]          csr_num;
        logic [31:0]          csr_wmask;
        logic [31:0]          csr_wvalue;
        logic                 ertn;
        logic [EX_TYPE_W-1:0] ex_type;
        logic [31:0]          result;
        logic                 res_from_mem;
        logic                 gr_we;
        logic [4:0]           dest;
        logic [31:0]          pc;
        logic [31:0]          inst;
    } exe_bus_t;
endpackage

// File: rtl/alu.sv
// Combinational ALU. alu_op is one-hot:
// [0] add [1] sub [2] slt [3] sltu [4] and [5] nor [6] or [7] xor
// [8] sll [9] srl [10] sra [11] lui (passes src2).
// Ports: alu_op, alu_src1, alu_src2 in; alu_result out.
module alu (
    input  logic [11:0] alu_op,
    input  logic [31:0] alu_src1,
    input  logic [31:0] alu_src2,
    output logic [31:0] alu_result
);
    always_comb begin
        alu_result = 32'h0;
        if (alu_op[0])       alu_result = alu_src1 + alu_src2;
        else if (alu_op[1])  alu_result = alu_src1 - alu_src2;
        else if (alu_op[2])  alu_result = {31'h0, $signed(alu_src1) < $signed(alu_src2)};
        else if (alu_op[3])  alu_result = {31'h0, alu_src1 < alu_src2};
        else if (alu_op[4])  alu_result = alu_src1 & alu_src2;
        else if (alu_op[5])  alu_result = ~(alu_src1 | alu_src2);
        else if (alu_op[6])  alu_result = alu_src1 | alu_src2;
        else if (alu_op[7])  alu_result = alu_src1 ^ alu_src2;
        else if (alu_op[8])  alu_result = alu_src1 << alu_src2[4:0];
        else if (alu_op[9])  alu_result = alu_src1 >> alu_src2[4:0];
        else if (alu_op[10]) alu_result = $signed(alu_src1) >>> alu_src2[4:0];
        else if (alu_op[11]) alu_result = alu_src2;
    end
endmodule

// File: rtl/div_unit.sv
// Iterative 32-bit restoring divider, one quotient bit per cycle.
// Ports: clk, resetn (sync, active-low), flush (abort to IDLE), start (request
// held while the dividing instruction occupies EXE), div_signed, a, b in;
// done, q, r out.
//
// state | meaning
// IDLE  | waiting for start; operands captured on start
// BUSY  | one restoring step per cycle, cnt 31 -> 0
// DONE  | q/r valid and held until start drops
module div_unit
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        start,
    input  logic        div_signed,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        done,
    output logic [31:0] q,
    output logic [31:0] r
);
    div_state_t  state, state_nxt;
    logic [4:0]  cnt;
    logic [31:0] quot, rem, divisor;
    logic        q_neg, r_neg, b_zero;
    logic [32:0] partial, diff;

    // rem < divisor <= 2^31, so partial fits 32 bits and diff[32] is the borrow.
    assign partial = {1'b0, rem[30:0], quot[31]} | {rem[31], 32'h0};
    assign diff    = partial - {1'b0, divisor};

    always_ff @(posedge clk) begin
        if (!resetn || flush) state <= IDLE;
        else                  state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = BUSY;
            BUSY:    if (cnt == 5'd0) state_nxt = DONE;
            DONE:    if (!start) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt     <= 5'd0;
            quot    <= 32'h0;
            rem     <= 32'h0;
            divisor <= 32'h0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            b_zero  <= 1'b0;
        end else if (state == IDLE && start) begin
            cnt     <= 5'd31;
            quot    <= (div_signed && a[31]) ? -a : a;
            rem     <= 32'h0;
            divisor <= (div_signed && b[31]) ? -b : b;
            q_neg   <= div_signed && (a[31] ^ b[31]);
            r_neg   <= div_signed && a[31];
            b_zero  <= (b == 32'h0);
        end else if (state == BUSY) begin
            cnt  <= cnt - 5'd1;
            rem  <= diff[32] ? partial[31:0] : diff[31:0];
            quot <= {quot[30:0], ~diff[32]};
        end
    end

    // Divide by zero leaves rem = |a|, which the sign fix-up restores to a.
    assign done = (state == DONE);
    assign q    = b_zero ? 32'hFFFF_FFFF : (q_neg ? -quot : quot);
    assign r    = r_neg ? -rem : rem;
endmodule

// File: rtl/exe_stage.sv
// EXE stage: ALU, iterative divider, optional multiplier, data-SRAM request,
// misalignment (ALE) detection and forwarding of the pending write to ID.
// Optional multiplier: compiled in when EXE_MUL_EN is defined; otherwise
// mul/mulh/mulhu produce 0.
// Ports: clk, resetn (sync, active-low); id_to_exe_valid/exe_allow_in/
// id_to_exe_bus from ID; exe_to_mem_valid/mem_allow_in/exe_to_mem_bus to MEM;
// data_sram_en/we/addr/wdata request; exe_fwd_bus {we,is_load,dest,result}
// to ID; mem_ex (exception or ertn in MEM); flush from WB.
module exe_stage
    import cpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 id_to_exe_valid,
    output logic                 exe_allow_in,
    input  logic [ID_BUS_W-1:0]  id_to_exe_bus,
    output logic                 exe_to_mem_valid,
    input  logic                 mem_allow_in,
    output logic [EXE_BUS_W-1:0] exe_to_mem_bus,
    output logic                 data_sram_en,
    output logic [3:0]           data_sram_we,
    output logic [31:0]          data_sram_addr,
    output logic [31:0]          data_sram_wdata,
    output logic [FWD_BUS_W-1:0] exe_fwd_bus,
    input  logic                 mem_ex,
    input  logic                 flush
);
    id_bus_t     ex;
    exe_bus_t    out_bus;
    logic        exe_valid, ready_go;
    logic        is_div, is_mul, div_signed, div_start, div_done;
    logic [31:0] div_q, div_r, div_res, mul_res, alu_res, result;
    logic        ale, res_from_mem, we_block;
    logic [3:0]  st_we;
    logic [31:0] st_wdata;

    always_ff @(posedge clk) begin
        if (!resetn)           exe_valid <= 1'b0;
        else if (flush)        exe_valid <= 1'b0;
        else if (exe_allow_in) exe_valid <= id_to_exe_valid;
    end

    always_ff @(posedge clk) begin
        if (!resetn)                              ex <= '0;
        else if (id_to_exe_valid && exe_allow_in) ex <= id_bus_t'(id_to_exe_bus);
    end

    alu u_alu (
        .alu_op     (ex.alu_op),
        .alu_src1   (ex.src1),
        .alu_src2   (ex.src2),
        .alu_result (alu_res)
    );

    assign is_div     = |ex.div_op;
    assign div_signed = ex.div_op[DIV_DIV] | ex.div_op[DIV_MOD];
    // start drops on the handoff cycle so the divider returns to IDLE even
    // when the next instruction latched behind it is another divide.
    assign div_start  = exe_valid & is_div & ~flush & ~(div_done & mem_allow_in);

    div_unit u_div (
        .clk        (clk),
        .resetn     (resetn),
        .flush      (flush),
        .start      (div_start),
        .div_signed (div_signed),
        .a          (ex.src1),
        .b          (ex.src2),
        .done       (div_done),
        .q          (div_q),
        .r          (div_r)
    );

    assign div_res = (ex.div_op[DIV_DIV] | ex.div_op[DIV_DIVU]) ? div_q : div_r;
    assign is_mul  = |ex.mul_op;

`ifdef EXE_MUL_EN
    logic [63:0] prod_s;
    logic [31:0] prod_u_hi, unused_prod_u_lo;
    assign prod_s = {{32{ex.src1[31]}}, ex.src1} * {{32{ex.src2[31]}}, ex.src2};
    assign {prod_u_hi, unused_prod_u_lo} = {32'h0, ex.src1} * {32'h0, ex.src2};
    always_comb begin
        mul_res = 32'h0;
        if (ex.mul_op[MUL_MUL])        mul_res = prod_s[31:0];
        else if (ex.mul_op[MUL_MULH])  mul_res = prod_s[63:32];
        else if (ex.mul_op[MUL_MULHU]) mul_res = prod_u_hi;
    end
`else
    assign mul_res = 32'h0;
`endif

    assign result = is_div ? div_res : (is_mul ? mul_res : alu_res);

    assign ready_go         = ~is_div | div_done;
    assign exe_allow_in     = ~exe_valid | (ready_go & mem_allow_in);
    assign exe_to_mem_valid = exe_valid & ready_go;

    assign ale = ((ex.mem_op[MEM_LD_H] | ex.mem_op[MEM_LD_HU] | ex.mem_op[MEM_ST_H]) & result[0])
               | ((ex.mem_op[MEM_LD_W] | ex.mem_op[MEM_ST_W]) & (result[1:0] != 2'b00));
    assign res_from_mem = |ex.mem_op[MEM_LD_B:MEM_LD_HU];

    always_comb begin
        st_we    = 4'h0;
        st_wdata = ex.st_data;
        if (ex.mem_op[MEM_ST_B]) begin
            st_we    = 4'b0001 << result[1:0];
            st_wdata = {4{ex.st_data[7:0]}};
        end else if (ex.mem_op[MEM_ST_H]) begin
            st_we    = 4'b0011 << result[1:0];
            st_wdata = {2{ex.st_data[15:0]}};
        end else if (ex.mem_op[MEM_ST_W]) begin
            st_we    = 4'hF;
        end
    end

    assign we_block        = (|ex.ex_type) | ale | mem_ex | flush | ~exe_valid;
    assign data_sram_en    = exe_valid & (|ex.mem_op);
    assign data_sram_we    = we_block ? 4'h0 : st_we;
    assign data_sram_addr  = result;
    assign data_sram_wdata = st_wdata;

    always_comb begin
        out_bus              = '0;
        out_bus.csr_we       = ex.csr_we;
        out_bus.csr_num      = ex.csr_num;
        out_bus.csr_wmask    = ex.csr_wmask;
        out_bus.csr_wvalue   = ex.csr_wvalue;
        out_bus.ertn         = ex.ertn;
        out_bus.ex_type      = ex.ex_type | (EX_TYPE_W'(ale) << ALE_BIT);
        out_bus.result       = result;
        out_bus.res_from_mem = res_from_mem;
        out_bus.gr_we        = ex.gr_we;
        out_bus.dest         = ex.dest;
        out_bus.pc           = ex.pc;
        out_bus.inst         = ex.inst;
    end

    assign exe_to_mem_bus = out_bus;
    assign exe_fwd_bus    = {exe_valid & ex.gr_we, res_from_mem, ex.dest, result};
endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- EXE stage of the 5-stage LoongArch pipeline: IF, ID, EXE, MEM, WB.
- Sits between ID and MEM.
- Computes the ALU result, runs 32-bit signed/unsigned division on an iterative sub-module, and issues the data-SRAM request.
- Detects load/store misalignment (ALE) and forwards its pending write to ID for bypass and load-use stall.

Parameters:
- EX_TYPE_W, 6, width of the exception-type vector carried down the pipe.
- ALE_BIT, 5, index in ex_type set by this stage on misaligned access.
- ID_BUS_W, 279, width of id_to_exe_bus.
- EXE_BUS_W, 189, width of exe_to_mem_bus.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- id_to_exe_valid  in  1  ID holds a valid instruction
- exe_allow_in  out  1  EXE can accept from ID this cycle
- id_to_exe_bus  in  ID_BUS_W  {csr_we,csr_num[13:0],csr_wmask[31:0],csr_wvalue[31:0],ertn,ex_type,alu_op[11:0],src1[31:0],src2[31:0],st_data[31:0],div_op[3:0]{div,mod,divu,modu},mul_op[2:0]{mul,mulh,mulhu},mem_op[7:0]{ld_b,ld_h,ld_w,ld_bu,ld_hu,st_b,st_h,st_w},gr_we,dest[4:0],pc[31:0],inst[31:0]}
- exe_to_mem_valid  out  1  valid to MEM
- mem_allow_in  in  1  MEM can accept
- exe_to_mem_bus  out  EXE_BUS_W  {csr_we,csr_num,csr_wmask,csr_wvalue,ertn,ex_type,result[31:0],res_from_mem,gr_we,dest,pc,inst}
- data_sram_en  out  1  request enable
- data_sram_we  out  4  byte write enables
- data_sram_addr  out  32  byte address = result
- data_sram_wdata  out  32  replicated store data
- exe_fwd_bus  out  39  {we,is_load,dest[4:0],result[31:0]}
- mem_ex  in  1  MEM holds an exception or ertn
- flush  in  1  wb_ex | ertn_flush from WB

Behaviour:
- Reset: exe_valid=0, divider IDLE. Outputs are then exe_to_mem_valid=0, data_sram_en=0, data_sram_we=0, exe_fwd_bus.we=0.
- Pipeline register: the bus latches on id_to_exe_valid & exe_allow_in.
- exe_allow_in = ~exe_valid | (ready_go & mem_allow_in).
- exe_to_mem_valid = exe_valid & ready_go.
- flush has priority over everything: exe_valid<=0 and divider->IDLE next cycle, including mid-division.
- ready_go = 1 for non-divide instructions. For a divide, ready_go = 1 only in divider DONE.
- Divider FSM (div_unit):
  - IDLE -> BUSY when exe_valid & any div_op & no flush; operands captured as absolute values plus sign flags.
  - BUSY: one restoring step per cycle; counter counts 31 down to 0; ->DONE after the 32nd step.
  - DONE: result held; ->IDLE when mem_allow_in. Total EXE occupancy is 34 cycles minimum.
- Divide sign rules:
  - Quotient sign = s1^s2; remainder sign = s1.
  - Divide by zero: q=0xFFFFFFFF, r=src1.
  - 0x80000000 / 0xFFFFFFFF signed: q=0x80000000, r=0.
- result selection: the div/mod output when div_op≠0, else the mul output, else the ALU output.
- Misalignment:
  - ld_h/ld_hu/st_h with addr[0]=1 -> ALE.
  - ld_w/st_w with addr[1:0]≠0 -> ALE.
  - Byte accesses never raise ALE.
  - ALE sets ex_type[ALE_BIT]; other bits pass through.
- Memory request:
  - data_sram_en = exe_valid & any mem_op.
  - data_sram_we is forced to 0 when any of: incoming ex_type≠0, ALE, mem_ex, flush, ~exe_valid.
  - st_b: we = 1<<addr[1:0], wdata = {4{st_data[7:0]}}.
  - st_h: we = 4'b0011<<addr[1:0], wdata = {2{st_data[15:0]}}.
  - st_w: we = 4'hF, wdata = st_data.
- res_from_mem = any load op.
- Forwarding: exe_fwd_bus.we = exe_valid & gr_we; is_load = res_from_mem. The value equals result only once ready_go=1; ID must stall on (is_load | ~ready_go) hazards.
- CSR fields, ertn, pc and inst pass through unchanged.

Optional Feature:
- EXE_MUL_EN defined: the mul/mulh/mulhu single-cycle multiplier is compiled in. mul returns low 32 bits, mulh the signed high 32 bits, mulhu the unsigned high 32 bits.
- EXE_MUL_EN undefined: no multiplier is synthesized and mul ops produce result 0. Handshake is unchanged.

Decomposition:
- Shared package cpu_pkg holds:
  - bus widths and field offsets for both buses;
  - EX_TYPE_W and ALE_BIT;
  - mem_op and div_op bit indices;
  - the div FSM state enum {IDLE,BUSY,DONE}.
- One sub-module div_unit:
  - inputs clk, resetn, flush, start, signed, a, b;
  - outputs done, q, r.
- The existing combinational ALU is instantiated as-is.

Test Plan:
- div: src1=0xFFFFFFF9 (-7), src2=2 -> after 34 cycles q=0xFFFFFFFD, mod r=0xFFFFFFFF; exe_allow_in=0 throughout BUSY.
- divu: src1=7, src2=0 -> q=0xFFFFFFFF, modu r=7. div 0x80000000/0xFFFFFFFF -> q=0x80000000.
- st_h with addr 0x1002, st_data=0x1234ABCD -> data_sram_we=4'b1100, wdata=0xABCDABCD.
- st_w with addr 0x1001 -> ALE bit set in ex_type, data_sram_we=0, exe_to_mem_valid=1.
- flush asserted at BUSY cycle 10 -> next cycle exe_valid=0 and divider IDLE. The next div completes normally.
- mem_ex=1 during st_b -> data_sram_we=0. mulhu 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE with EXE_MUL_EN, 0 without.
